// File: rtl/q_sys_p2b_pkg.sv
// Shared constants, FSM state type and byte-encoding helpers for the
// packets-to-bytes encoder.
package q_sys_p2b_pkg;

  localparam logic [7:0] SOP_CHAR  = 8'h7A;
  localparam logic [7:0] EOP_CHAR  = 8'h7B;
  localparam logic [7:0] CHAN_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR  = 8'h7D;
  localparam logic [7:0] ESC_XOR   = 8'h20;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SOP       = 3'd1,
    CHAN      = 3'd2,
    CHAN_ESC  = 3'd3,
    CHAN_BYTE = 3'd4,
    EOP       = 3'd5,
    DATA_ESC  = 3'd6,
    DATA      = 3'd7
  } p2b_state_e;

  function automatic logic needs_escape(input logic [7:0] b);
    return (b >= SOP_CHAR) && (b <= ESC_CHAR);
  endfunction

  function automatic p2b_state_e data_state(input logic [7:0] d);
    return needs_escape(d) ? DATA_ESC : DATA;
  endfunction

  function automatic p2b_state_e after_chan(input logic eop, input logic [7:0] d);
    return eop ? EOP : data_state(d);
  endfunction

  function automatic p2b_state_e after_sop(input logic send, input logic eop,
                                           input logic [7:0] d);
    return send ? CHAN : after_chan(eop, d);
  endfunction

  function automatic p2b_state_e first_state(input logic sop, input logic send,
                                             input logic eop, input logic [7:0] d);
    return sop ? SOP : after_sop(send, eop, d);
  endfunction

  // Byte presented on the wire while the FSM sits in state st.
  function automatic logic [7:0] encode_byte(input p2b_state_e st, input logic [7:0] ch,
                                             input logic [7:0] d);
    case (st)
      SOP:       return SOP_CHAR;
      CHAN:      return CHAN_CHAR;
      CHAN_ESC:  return ESC_CHAR;
      CHAN_BYTE: return needs_escape(ch) ? (ch ^ ESC_XOR) : ch;
      EOP:       return EOP_CHAR;
      DATA_ESC:  return ESC_CHAR;
      DATA:      return needs_escape(d) ? (d ^ ESC_XOR) : d;
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/q_sys_master_0_p2b.sv
// Avalon-ST packet to escaped byte-stream encoder for the JTAG byte link.
// Optional macro P2B_CHAN_ON_SOP_EN forces the channel sequence on every SOP beat.
module q_sys_master_0_p2b
  import q_sys_p2b_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data
);

  p2b_state_e state_q, state_d;
  logic       out_valid_q;
  logic [7:0] out_data_q, out_data_d;
  logic       sop_q, eop_q, send_q;
  logic [7:0] data_q, chan_q;
  logic       chan_valid_q;
  logic [7:0] last_chan_q;

  logic       accept_s, send_s;
  logic       eff_sop_s, eff_eop_s, eff_send_s;
  logic [7:0] eff_data_s, eff_chan_s, in_chan_byte_s;

  assign in_chan_byte_s = 8'(in_channel);
  assign in_ready       = (state_q == IDLE) || ((state_q == DATA) && out_ready);
  assign accept_s       = in_valid && in_ready;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;

  // Next-state and next-byte selection; a beat accepted this cycle replaces the held one.
  always_comb begin
    send_s = !chan_valid_q || (in_chan_byte_s != last_chan_q);
`ifdef P2B_CHAN_ON_SOP_EN
    send_s = send_s || in_startofpacket;
`endif
    if (accept_s) begin
      eff_sop_s  = in_startofpacket;
      eff_eop_s  = in_endofpacket;
      eff_send_s = send_s;
      eff_data_s = in_data;
      eff_chan_s = in_chan_byte_s;
    end else begin
      eff_sop_s  = sop_q;
      eff_eop_s  = eop_q;
      eff_send_s = send_q;
      eff_data_s = data_q;
      eff_chan_s = chan_q;
    end

    state_d = state_q;
    case (state_q)
      IDLE:      state_d = accept_s ? first_state(eff_sop_s, eff_send_s, eff_eop_s, eff_data_s)
                                    : IDLE;
      SOP:       if (out_ready) state_d = after_sop(eff_send_s, eff_eop_s, eff_data_s);
                 else           state_d = state_q;
      CHAN:      if (out_ready) state_d = needs_escape(eff_chan_s) ? CHAN_ESC : CHAN_BYTE;
                 else           state_d = state_q;
      CHAN_ESC:  if (out_ready) state_d = CHAN_BYTE;
                 else           state_d = state_q;
      CHAN_BYTE: if (out_ready) state_d = after_chan(eff_eop_s, eff_data_s);
                 else           state_d = state_q;
      EOP:       if (out_ready) state_d = data_state(eff_data_s);
                 else           state_d = state_q;
      DATA_ESC:  if (out_ready) state_d = DATA;
                 else           state_d = state_q;
      DATA:      if (out_ready) state_d = accept_s
                                  ? first_state(eff_sop_s, eff_send_s, eff_eop_s, eff_data_s)
                                  : IDLE;
                 else           state_d = state_q;
      default:   state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      out_data_d = out_data_q;
    end else begin
      out_data_d = encode_byte(state_d, eff_chan_s, eff_data_s);
    end
  end

  // State, registered outputs, captured beat and channel tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      send_q       <= 1'b0;
      data_q       <= 8'h00;
      chan_q       <= 8'h00;
      chan_valid_q <= 1'b0;
      last_chan_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != IDLE);
      out_data_q  <= out_data_d;
      if (accept_s) begin
        sop_q  <= in_startofpacket;
        eop_q  <= in_endofpacket;
        send_q <= send_s;
        data_q <= in_data;
        chan_q <= in_chan_byte_s;
        if (send_s) begin
          chan_valid_q <= 1'b1;
          last_chan_q  <= in_chan_byte_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_q_sys_master_0_p2b.sv
// Directed self-checking bench for the packets-to-bytes encoder.
module tb_q_sys_master_0_p2b;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_ready;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_startofpacket = 1'b0;
  logic       in_endofpacket = 1'b0;
  logic [7:0] in_channel = 8'h00;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_ptr = 0;
  logic [7:0] got_q[$];
  int         stamp_q[$];
  logic [7:0] exp_q[$];

  q_sys_master_0_p2b #(.CHANNEL_WIDTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_ready         (in_ready),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .in_channel       (in_channel),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every byte that will transfer on the coming rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got_q.push_back(out_data);
      stamp_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic s, input logic e, input logic [7:0] ch,
                           input logic [7:0] d);
    int g;
    in_startofpacket = s;
    in_endofpacket   = e;
    in_channel       = ch;
    in_data          = d;
    in_valid         = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag);
    int g;
    g = 0;
    while ((got_q.size() - rd_ptr) < exp_q.size() && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk({tag, "_count"}, got_q.size() - rd_ptr, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd_ptr < got_q.size()) begin
        chk($sformatf("%s_b%0d", tag, i), {24'd0, got_q[rd_ptr]}, {24'd0, exp_q[i]});
        rd_ptr++;
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] pat;
    logic        prev_stall;
    logic [7:0]  prev_data;
    int          base;

    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    send_beat(1'b1, 1'b0, 8'h00, 8'h41);
    exp_q = '{8'h7A, 8'h7C, 8'h00, 8'h41};
    check_out("sop_beat");

    send_beat(1'b0, 1'b1, 8'h00, 8'h7B);
    exp_q = '{8'h7B, 8'h7D, 8'h5B};
    check_out("eop_esc");

    send_beat(1'b1, 1'b1, 8'h7D, 8'h10);
    exp_q = '{8'h7A, 8'h7C, 8'h7D, 8'h5D, 8'h7B, 8'h10};
    check_out("sop_eop_chesc");

    // Back-to-back unescaped beats on an unchanged channel.
    base = got_q.size();
    for (int i = 0; i < 16; i++) begin
      in_startofpacket = 1'b0;
      in_endofpacket   = 1'b0;
      in_channel       = 8'h7D;
      in_data          = 8'(i);
      in_valid         = 1'b1;
      chk($sformatf("stream_ready%0d", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
              8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    check_out("stream");
    if (got_q.size() >= base + 16) begin
      chk("stream_span", stamp_q[base + 15] - stamp_q[base], 32'd15);
    end

    // Escaped channel and data under a stalling sink.
    send_beat(1'b1, 1'b1, 8'h7A, 8'h7C);
    pat = 32'hA5C3_9B36;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    base = got_q.size() - rd_ptr;
    for (int i = 0; i < 80 && (got_q.size() - rd_ptr) < 7; i++) begin
      if (prev_stall) begin
        chk($sformatf("hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
        chk($sformatf("hold_data%0d", i), {24'd0, out_data}, {24'd0, prev_data});
      end
      out_ready = pat[i % 32];
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    exp_q = '{8'h7A, 8'h7C, 8'h7D, 8'h5A, 8'h7B, 8'h7D, 8'h5C};
    check_out("stall_seq");

    // Reset while the channel byte is on the wire.
    send_beat(1'b1, 1'b0, 8'h00, 8'h22);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("chbyte_valid", {31'd0, out_valid}, 32'd1);
    chk("chbyte_data", {24'd0, out_data}, 32'h00);
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", {24'd0, out_data}, 32'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("postrst_ready", {31'd0, in_ready}, 32'd1);
    rd_ptr = got_q.size();
    send_beat(1'b1, 1'b0, 8'h00, 8'h33);
    exp_q = '{8'h7A, 8'h7C, 8'h00, 8'h33};
    check_out("after_rst");

    // SOP on an unchanged channel.
    send_beat(1'b1, 1'b1, 8'h00, 8'h44);
`ifdef P2B_CHAN_ON_SOP_EN
    exp_q = '{8'h7A, 8'h7C, 8'h00, 8'h7B, 8'h44};
`else
    exp_q = '{8'h7A, 8'h7B, 8'h44};
`endif
    check_out("sop_same_ch");

    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
